// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
package rr_arbiter4_pkg;

    localparam int NREQ         = 4;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbState_t;

endpackage

// File: rtl/rr_arbiter4_decoder2to4.sv
// Plain 2-to-4 one-hot decoder driving the shared resource select lines.
module decoder2to4 (
    input  logic [1:0] in,
    output logic [3:0] out
);

    assign out = 4'b0001 << in;

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with a maximum-hold timeout;
// the owner index is registered and decoded to a one-hot grant.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_id,
    output logic            gnt_valid,
    output logic            preempt
);

    arbState_t        r_state;
    logic [1:0]       r_gnt_id;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_preempt;

    arbState_t        w_state_nxt;
    logic [1:0]       w_id_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_preempt_nxt;

    logic [NREQ-1:0]  w_dec_out;
    logic [NREQ-1:0]  w_others;
    logic [1:0]       w_pick_all;
    logic [1:0]       w_pick_others;
    logic             w_at_limit;
    logic             w_valid;

    // First set bit of reqs, searched circularly starting at start.
    function automatic logic [1:0] rrPick(input logic [NREQ-1:0] reqs,
                                          input logic [1:0]      start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = start + 2'(i);
            if (!found && reqs[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    decoder2to4 u_decoder (
        .in  (r_gnt_id),
        .out (w_dec_out)
    );

    assign w_valid       = (r_state == GRANT);
    assign w_others      = req & ~w_dec_out;
    assign w_pick_all    = rrPick(req, r_ptr);
    assign w_pick_others = rrPick(w_others, r_ptr);
    assign w_at_limit    = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    // A release takes precedence over a timeout, so preempt only fires when the owner still wants the resource.
    always_comb begin
        w_state_nxt   = r_state;
        w_id_nxt      = r_gnt_id;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_hold_cnt;
        w_preempt_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = GRANT;
                    w_id_nxt    = w_pick_all;
                    w_ptr_nxt   = w_pick_all + 2'd1;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!req[r_gnt_id]) begin
                    if (|w_others) begin
                        w_id_nxt  = w_pick_others;
                        w_ptr_nxt = w_pick_others + 2'd1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_at_limit && (|w_others)) begin
                    w_id_nxt      = w_pick_others;
                    w_ptr_nxt     = w_pick_others + 2'd1;
                    w_cnt_nxt     = '0;
                    w_preempt_nxt = 1'b1;
                end else if (!w_at_limit) begin
                    w_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt_id   <= 2'd0;
            r_ptr      <= 2'd0;
            r_hold_cnt <= '0;
            r_preempt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_id   <= w_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_cnt_nxt;
            r_preempt  <= w_preempt_nxt;
        end
    end

    assign gnt       = w_dec_out & {NREQ{w_valid}};
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = w_valid;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4 with MAX_HOLD=16.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int totalChecks = 0;
    int badChecks   = 0;

    logic [1:0] rrSeq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rr_arbiter4 #(
        .MAX_HOLD (16),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic expectGrant(input string tag, input logic [3:0] g,
                               input logic [1:0] id, input logic p);
        checkOutput(tag, {gnt, gnt_id, gnt_valid, preempt}, {g, id, 1'b1, p});
    endtask

    task automatic expectIdle(input string tag);
        checkOutput(tag, {2'b00, gnt, gnt_valid, preempt}, 8'h00);
    endtask

    task automatic doReset;
        rst = 1'b1;
        applyStimulus(4'b0000);
        repeat (3) stepCycle;
        checkOutput("reset_state", {gnt, gnt_id, gnt_valid, preempt}, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req = 4'b0000;

        // reset then idle
        doReset;
        for (int n = 0; n < 5; n++) begin
            stepCycle;
            checkOutput($sformatf("idle_%0d", n), {gnt, gnt_id, gnt_valid, preempt}, 8'h00);
        end

        // single request latency and release
        applyStimulus(4'b0100);
        stepCycle;
        for (int n = 0; n < 9; n++) begin
            expectGrant($sformatf("single_%0d", n), 4'b0100, 2'd2, 1'b0);
            stepCycle;
        end
        expectGrant("single_last", 4'b0100, 2'd2, 1'b0);
        applyStimulus(4'b0000);
        stepCycle;
        expectIdle("single_release");

        // round-robin fairness with back-to-back handoff
        doReset;
        applyStimulus(4'b1111);
        stepCycle;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) begin
                expectGrant($sformatf("rr_own%0d_c%0d", k, c),
                            4'b0001 << rrSeq[k], rrSeq[k], 1'b0);
                if (c == 0) applyStimulus(4'b1111);
                if (c == 2) applyStimulus(4'b1111 & ~(4'b0001 << rrSeq[k]));
                stepCycle;
            end
        end
        applyStimulus(4'b0000);
        stepCycle;
        expectIdle("rr_end");

        // timeout preemption
        doReset;
        applyStimulus(4'b0001);
        stepCycle;
        for (int n = 1; n <= 16; n++) begin
            expectGrant($sformatf("to_own0_%0d", n), 4'b0001, 2'd0, 1'b0);
            if (n == 1) applyStimulus(4'b0011);
            stepCycle;
        end
        expectGrant("to_preempt", 4'b0010, 2'd1, 1'b1);
        stepCycle;
        expectGrant("to_pulse_end", 4'b0010, 2'd1, 1'b0);
        applyStimulus(4'b0001);
        stepCycle;
        expectGrant("to_regrant0", 4'b0001, 2'd0, 1'b0);
        applyStimulus(4'b0000);
        stepCycle;
        expectIdle("to_end");

        // release coinciding with timeout is a plain release
        doReset;
        applyStimulus(4'b0011);
        stepCycle;
        for (int n = 1; n <= 16; n++) begin
            expectGrant($sformatf("relto_own0_%0d", n), 4'b0001, 2'd0, 1'b0);
            if (n == 16) applyStimulus(4'b0010);
            stepCycle;
        end
        expectGrant("relto_handoff", 4'b0010, 2'd1, 1'b0);
        applyStimulus(4'b0000);
        stepCycle;
        expectIdle("relto_end");

        // saturation without contention
        applyStimulus(4'b1000);
        stepCycle;
        for (int n = 0; n < 40; n++) begin
            expectGrant($sformatf("sat_%0d", n), 4'b1000, 2'd3, 1'b0);
            stepCycle;
        end

        // asynchronous reset mid-grant, then pointer wrap
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_async", {gnt, gnt_id, gnt_valid, preempt}, 8'h00);
        stepCycle;
        rst = 1'b0;
        applyStimulus(4'b1001);
        stepCycle;
        expectGrant("post_rst_ptr0", 4'b0001, 2'd0, 1'b0);
        applyStimulus(4'b1000);
        stepCycle;
        expectGrant("post_rst_to3", 4'b1000, 2'd3, 1'b0);
        applyStimulus(4'b0011);
        stepCycle;
        expectGrant("wrap_to0", 4'b0001, 2'd0, 1'b0);
        applyStimulus(4'b0000);
        stepCycle;
        expectIdle("final_idle");

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
